// File: rtl/test_add_mul_i8_i8_i8_i8.sv
// Self-checking wrapper around an 8-bit multiply-add pipeline, y = (a*b + c) mod 256.
// Walks a fixed 8-entry vector table once after reset and raises sticky fail/finish flags.
module test_add_mul_i8_i8_i8_i8 #(
   parameter bit INJECT_FAULT = 1'b0
) (
   input  logic clock,
   input  logic reset,
   output logic fail,
   output logic finish
);

   localparam logic [3:0] N_VEC = 4'd8;

   logic [3:0] idx;
   logic       run;
   logic       last_vec;

   logic [7:0] vec_a;
   logic [7:0] vec_b;
   logic [7:0] vec_c;
   logic [7:0] vec_exp;
   logic [7:0] prod_lo;

   logic [7:0] p;
   logic [7:0] c_s1;
   logic [7:0] y;

   logic       v_s1;
   logic       v_s2;
   logic [7:0] e_s1;
   logic [7:0] e_s2;
   logic       l_s1;
   logic       l_s2;

   assign run      = (idx < N_VEC);
   assign last_vec = (idx == (N_VEC - 4'd1));

   always_comb begin
      vec_a   = 8'd0;
      vec_b   = 8'd0;
      vec_c   = 8'd0;
      vec_exp = 8'd0;
      case (idx)
         4'd0: begin vec_a = 8'd0;   vec_b = 8'd0;   vec_c = 8'd0;  vec_exp = 8'd0;   end
         4'd1: begin vec_a = 8'd1;   vec_b = 8'd1;   vec_c = 8'd1;  vec_exp = 8'd2;   end
         4'd2: begin vec_a = 8'd3;   vec_b = 8'd4;   vec_c = 8'd5;  vec_exp = 8'd17;  end
         // The only entry INJECT_FAULT alters, so the checker can prove it catches a miss.
         4'd3: begin vec_a = 8'd255; vec_b = 8'd1;   vec_c = 8'd1;  vec_exp = 8'd0 ^ {7'd0, INJECT_FAULT}; end
         4'd4: begin vec_a = 8'd16;  vec_b = 8'd16;  vec_c = 8'd0;  vec_exp = 8'd0;   end
         4'd5: begin vec_a = 8'd15;  vec_b = 8'd17;  vec_c = 8'd2;  vec_exp = 8'd1;   end
         4'd6: begin vec_a = 8'd255; vec_b = 8'd255; vec_c = 8'd10; vec_exp = 8'd11;  end
         4'd7: begin vec_a = 8'd100; vec_b = 8'd2;   vec_c = 8'd27; vec_exp = 8'd227; end
         default: ;
      endcase
   end

   // 8-bit assignment context keeps only the low byte of the product.
   assign prod_lo = vec_a * vec_b;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx <= 4'd0;
      end else if (run) begin
         idx <= idx + 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p    <= 8'd0;
         c_s1 <= 8'd0;
         e_s1 <= 8'd0;
         l_s1 <= 1'b0;
         v_s1 <= 1'b0;
      end else begin
         v_s1 <= run;
         if (run) begin
            p    <= prod_lo;
            c_s1 <= vec_c;
            e_s1 <= vec_exp;
            l_s1 <= last_vec;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         y    <= 8'd0;
         e_s2 <= 8'd0;
         l_s2 <= 1'b0;
         v_s2 <= 1'b0;
      end else begin
         y    <= p + c_s1;
         e_s2 <= e_s1;
         l_s2 <= l_s1;
         v_s2 <= v_s1;
      end
   end

   // Once finish is set the flags freeze, even if stale valids were still in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fail   <= 1'b0;
         finish <= 1'b0;
      end else if (v_s2 && !finish) begin
         if (y != e_s2) begin
            fail <= 1'b1;
         end
         if (l_s2) begin
            finish <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_test_add_mul_i8_i8_i8_i8.sv
// Bench for the multiply-add self-check wrapper: a clean and a fault-injected instance share
// clock and reset, and are checked against an arithmetic model of the vector table.
module tb_test_add_mul_i8_i8_i8_i8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic fail0, finish0, fail1, finish1;

   int checks = 0;
   int errors = 0;

   int a_tab[8]    = '{0, 1, 3, 255, 16, 15, 255, 100};
   int b_tab[8]    = '{0, 1, 4, 1, 16, 17, 255, 2};
   int c_tab[8]    = '{0, 1, 5, 1, 0, 2, 10, 27};
   int spec_exp[8] = '{0, 2, 17, 0, 0, 1, 11, 227};

   test_add_mul_i8_i8_i8_i8 #(.INJECT_FAULT(1'b0)) dut0 (
      .clock(clock), .reset(reset), .fail(fail0), .finish(finish0));
   test_add_mul_i8_i8_i8_i8 #(.INJECT_FAULT(1'b1)) dut1 (
      .clock(clock), .reset(reset), .fail(fail1), .finish(finish1));

   always #5 clock = ~clock;

   function automatic int ref_y(input int k);
      return (a_tab[k] * b_tab[k] + c_tab[k]) % 256;
   endfunction

   // Edge at which fail should first rise (vector k compares at E(k+3)); 1000 means never.
   function automatic int fail_edge(input bit fault);
      int expv;
      for (int k = 0; k < 8; k++) begin
         expv = spec_exp[k];
         if (fault && k == 3) expv = expv ^ 1;
         if (ref_y(k) != expv) return k + 3;
      end
      return 1000;
   endfunction

   task automatic apply_reset(input int n);
      @(negedge clock);
      reset = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      n = $urandom_range(16, 24);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         checks++;
         if (fail0 !== 1'b0 || finish0 !== 1'b0 || fail1 !== 1'b0 || finish1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags cyc%0d got %b%b%b%b want 0000", i, fail0, finish0, fail1, finish1);
         end
         checks++;
         if (dut0.idx !== 4'd0 || dut0.y !== 8'd0) begin
            errors++;
            $display("FAIL reset_state cyc%0d idx %0d y %0d want 0 0", i, dut0.idx, dut0.y);
         end
      end
   endtask

   task automatic test_nominal();
      int fe0, fe1;
      fe0 = fail_edge(1'b0);
      fe1 = fail_edge(1'b1);
      apply_reset($urandom_range(2, 6));
      release_reset();
      for (int e = 1; e <= 14; e++) begin
         @(posedge clock); #1;
         checks++;
         if (fail0 !== 1'(e >= fe0) || finish0 !== 1'(e >= 10)) begin
            errors++;
            $display("FAIL nominal_clean E%0d fail/finish %b%b want %b%b", e, fail0, finish0, 1'(e >= fe0), 1'(e >= 10));
         end
         checks++;
         if (fail1 !== 1'(e >= fe1) || finish1 !== 1'(e >= 10)) begin
            errors++;
            $display("FAIL nominal_fault E%0d fail/finish %b%b want %b%b", e, fail1, finish1, 1'(e >= fe1), 1'(e >= 10));
         end
         if (e >= 2 && e <= 9) begin
            checks++;
            if (dut0.y !== 8'(ref_y(e - 2))) begin
               errors++;
               $display("FAIL nominal_y E%0d got %0d want %0d", e, dut0.y, ref_y(e - 2));
            end
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset($urandom_range(2, 6));
      release_reset();
      for (int e = 1; e <= 9; e++) begin
         @(posedge clock); #1;
         if (e == 5 || e == 6 || e == 8) begin
            checks++;
            if (dut0.y !== 8'(ref_y(e - 2))) begin
               errors++;
               $display("FAIL wrap_y V%0d got %0d want %0d", e - 2, dut0.y, ref_y(e - 2));
            end
            checks++;
            if (fail0 !== 1'b0) begin
               errors++;
               $display("FAIL wrap_fail V%0d got %b want 0", e - 2, fail0);
            end
         end
      end
   endtask

   task automatic test_mid_reset(input int abort_at);
      int fe1;
      fe1 = fail_edge(1'b1);
      apply_reset($urandom_range(2, 6));
      release_reset();
      repeat (abort_at) @(posedge clock);
      #2;
      checks++;
      if (fail1 !== 1'(abort_at >= fe1) || finish1 !== 1'(abort_at >= 10)) begin
         errors++;
         $display("FAIL mid_pre E%0d fail1/finish1 %b%b want %b%b", abort_at, fail1, finish1, 1'(abort_at >= fe1), 1'(abort_at >= 10));
      end
      reset = 1'b1;
      #1;
      checks++;
      if (fail0 !== 1'b0 || finish0 !== 1'b0 || fail1 !== 1'b0 || finish1 !== 1'b0 || dut0.idx !== 4'd0) begin
         errors++;
         $display("FAIL mid_async after E%0d got %b%b%b%b idx %0d want 0000 idx 0", abort_at, fail0, finish0, fail1, finish1, dut0.idx);
      end
      repeat ($urandom_range(1, 4)) @(negedge clock);
      reset = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         @(posedge clock); #1;
         if (e == 9 || e == 10 || e == 11) begin
            checks++;
            if (fail0 !== 1'b0 || finish0 !== 1'(e >= 10) || finish1 !== 1'(e >= 10) || fail1 !== 1'(e >= fe1)) begin
               errors++;
               $display("FAIL mid_rerun E%0d got %b%b%b%b want 0%b%b%b", e, fail0, finish0, fail1, finish1, 1'(e >= 10), 1'(e >= fe1), 1'(e >= 10));
            end
         end
      end
   endtask

   task automatic test_post_finish();
      apply_reset($urandom_range(2, 6));
      release_reset();
      repeat (10) @(posedge clock);
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         checks++;
         if (fail0 !== 1'b0 || finish0 !== 1'b1 || fail1 !== 1'b1 || finish1 !== 1'b1) begin
            errors++;
            $display("FAIL post_flags +%0d got %b%b%b%b want 0111", i, fail0, finish0, fail1, finish1);
         end
         checks++;
         if (dut0.idx !== 4'd8 || dut1.idx !== 4'd8 || dut0.y !== 8'(ref_y(7))) begin
            errors++;
            $display("FAIL post_state +%0d idx %0d/%0d y %0d want 8/8 %0d", i, dut0.idx, dut1.idx, dut0.y, ref_y(7));
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_wrap();
      test_mid_reset(4);
      test_mid_reset($urandom_range(5, 12));
      test_post_finish();
      test_nominal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
